// File: rtl/mode_arbiter.sv
// Board-level display arbiter: debounced NEXT/PREV buttons select one of N_MODES
// display sources, with a mode-number blanking interval shown on every switch.

module mode_arbiter_debounce #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = (DEBOUNCE_CYC < 1) ? 1 : $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYC);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;
  logic          press_q;

  // Any sample that agrees with the accepted level restarts the stability window.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == LIMIT) deb_d = ~deb_q;
      else                cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      press_q <= deb_d & ~deb_q;
    end
  end

  assign press_o = press_q;
endmodule

module mode_arbiter #(
  parameter int N_MODES      = 4,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int BLANK_CYC    = 50000000
) (
  input  logic                   IN_CLK,
  input  logic                   IN_RST,
  input  logic                   IN_BTN_NEXT,
  input  logic                   IN_BTN_PREV,
  input  logic [7*N_MODES-1:0]   IN_M_SEG0DATA,
  input  logic [7*N_MODES-1:0]   IN_M_SEG1DATA,
  input  logic [4*N_MODES-1:0]   IN_M_SEG0SELE,
  input  logic [4*N_MODES-1:0]   IN_M_SEG1SELE,
  input  logic [N_MODES-1:0]     IN_M_SEG0DP,
  input  logic [N_MODES-1:0]     IN_M_SEG1DP,
  input  logic [16*N_MODES-1:0]  IN_M_LED,
  output logic [N_MODES-1:0]     OUT_ENABLE,
  output logic [2:0]             OUT_MODE,
  output logic [6:0]             OUT_SEG0DATA,
  output logic [6:0]             OUT_SEG1DATA,
  output logic [3:0]             OUT_SEG0SELE,
  output logic [3:0]             OUT_SEG1SELE,
  output logic                   OUT_SEG0DP,
  output logic                   OUT_SEG1DP,
  output logic [15:0]            OUT_LED
);
  typedef enum logic {ST_BLANK, ST_RUN} state_e;

  localparam int              BW         = (BLANK_CYC < 2) ? 1 : $clog2(BLANK_CYC);
  localparam logic [BW-1:0]   BLANK_LAST = BW'(BLANK_CYC - 1);
  localparam logic [2:0]      MODE_LAST  = 3'(N_MODES - 1);

  function automatic logic [6:0] digit7(input logic [2:0] m);
    case (m)
      3'd0:    digit7 = 7'h3F;
      3'd1:    digit7 = 7'h06;
      3'd2:    digit7 = 7'h5B;
      3'd3:    digit7 = 7'h4F;
      3'd4:    digit7 = 7'h66;
      3'd5:    digit7 = 7'h6D;
      3'd6:    digit7 = 7'h7D;
      default: digit7 = 7'h07;
    endcase
  endfunction

  // press[0] = NEXT, press[1] = PREV
  logic [1:0] btn_raw, press;
  assign btn_raw = {IN_BTN_PREV, IN_BTN_NEXT};

  mode_arbiter_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb [1:0] (
    .clk_i   (IN_CLK),
    .rst_i   (IN_RST),
    .btn_i   (btn_raw),
    .press_o (press)
  );

  state_e          state_q, state_d;
  logic [2:0]      mode_q, mode_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            shown_q;

  logic [N_MODES-1:0] en_q, en_d;
  logic [6:0]         seg0d_q, seg0d_d, seg1d_q, seg1d_d;
  logic [3:0]         seg0s_q, seg0s_d, seg1s_q, seg1s_d;
  logic               dp0_q, dp0_d, dp1_q, dp1_d;
  logic [15:0]        led_q, led_d;

  // The blank counter only advances once the pins actually show the digit, so the
  // post-reset interval is as long as a switch interval.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      ST_BLANK: begin
        if (shown_q) begin
          if (bcnt_q == BLANK_LAST) begin
            state_d = ST_RUN;
            bcnt_d  = '0;
          end else begin
            bcnt_d  = bcnt_q + BW'(1);
          end
        end
      end
      ST_RUN: begin
        if (press[0] && !press[1]) begin
          mode_d  = (mode_q == MODE_LAST) ? 3'd0 : mode_q + 3'd1;
          state_d = ST_BLANK;
          bcnt_d  = '0;
        end else if (press[1] && !press[0]) begin
          mode_d  = (mode_q == 3'd0) ? MODE_LAST : mode_q - 3'd1;
          state_d = ST_BLANK;
          bcnt_d  = '0;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Pin values are built from next-state so a switch shows on the same edge as OUT_MODE.
  always_comb begin
    en_d    = '0;
    seg0d_d = '0;
    seg1d_d = '0;
    seg0s_d = '0;
    seg1s_d = '0;
    dp0_d   = 1'b0;
    dp1_d   = 1'b0;
    led_d   = '0;
    if (state_d == ST_RUN) begin
      for (int k = 0; k < N_MODES; k++) begin
        if (mode_d == 3'(k)) begin
          en_d[k] = 1'b1;
          seg0d_d = IN_M_SEG0DATA[7*k +: 7];
          seg1d_d = IN_M_SEG1DATA[7*k +: 7];
          seg0s_d = IN_M_SEG0SELE[4*k +: 4];
          seg1s_d = IN_M_SEG1SELE[4*k +: 4];
          dp0_d   = IN_M_SEG0DP[k];
          dp1_d   = IN_M_SEG1DP[k];
          led_d   = IN_M_LED[16*k +: 16];
        end
      end
    end else begin
      seg0s_d = 4'b0001;
      seg0d_d = digit7(mode_d);
    end
  end

  always_ff @(posedge IN_CLK) begin
    if (IN_RST) begin
      state_q <= ST_BLANK;
      mode_q  <= '0;
      bcnt_q  <= '0;
      shown_q <= 1'b0;
      en_q    <= '0;
      seg0d_q <= '0;
      seg1d_q <= '0;
      seg0s_q <= '0;
      seg1s_q <= '0;
      dp0_q   <= 1'b0;
      dp1_q   <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      bcnt_q  <= bcnt_d;
      shown_q <= (state_d == ST_BLANK);
      en_q    <= en_d;
      seg0d_q <= seg0d_d;
      seg1d_q <= seg1d_d;
      seg0s_q <= seg0s_d;
      seg1s_q <= seg1s_d;
      dp0_q   <= dp0_d;
      dp1_q   <= dp1_d;
      led_q   <= led_d;
    end
  end

  assign OUT_ENABLE   = en_q;
  assign OUT_MODE     = mode_q;
  assign OUT_SEG0DATA = seg0d_q;
  assign OUT_SEG1DATA = seg1d_q;
  assign OUT_SEG0SELE = seg0s_q;
  assign OUT_SEG1SELE = seg1s_q;
  assign OUT_SEG0DP   = dp0_q;
  assign OUT_SEG1DP   = dp1_q;
  assign OUT_LED      = led_q;
endmodule

// File: doc/mode_arbiter.md
# mode_arbiter

Top-level display/LED arbiter for the multi-mode board design. Several mode blocks (the text viewer and its siblings) each drive a full seven-segment/LED bus. This block owns the single set of physical pins and sequences which mode is active. It debounces next/prev buttons, enables exactly one mode at a time, and inserts a blanking interval on every switch that shows the new mode number.

## Interface
- N_MODES, 4, number of mode blocks, legal 2..8
- DEBOUNCE_CYC, 1000000, cycles a synchronized button level must be stable to be accepted
- BLANK_CYC, 50000000, length of the switch interval in cycles, ≥1
- IN_CLK  in  1  system clock
- IN_RST  in  1  reset, synchronous, active-high
- IN_BTN_NEXT  in  1  raw button, asynchronous, select next mode
- IN_BTN_PREV  in  1  raw button, asynchronous, select previous mode
- IN_M_SEG0DATA  in  7*N_MODES  per-mode seg0 segments, mode k at bits [7k+6:7k]
- IN_M_SEG1DATA  in  7*N_MODES  per-mode seg1 segments, same packing
- IN_M_SEG0SELE / IN_M_SEG1SELE  in  4*N_MODES each  per-mode digit selects
- IN_M_SEG0DP / IN_M_SEG1DP  in  N_MODES each  per-mode decimal points
- IN_M_LED  in  16*N_MODES  per-mode LED buses
- OUT_ENABLE  out  N_MODES  one-hot enable to mode blocks; all zero while blanking
- OUT_MODE  out  3  current mode index
- OUT_SEG0DATA, OUT_SEG1DATA  out  7  segments, active-high, bit0=a … bit6=g
- OUT_SEG0SELE, OUT_SEG1SELE  out  4  digit selects, active-high
- OUT_SEG0DP, OUT_SEG1DP  out  1  decimal points
- OUT_LED  out  16  LEDs

## Operation
- Each button path has a 2-FF synchronizer, then a debounce counter.
  - When the synchronized level differs from the debounced level, the counter increments; any return to equality clears it.
  - When the counter reaches DEBOUNCE_CYC, the debounced level flips and the counter clears.
  - A 0→1 flip of the debounced level emits a one-cycle press pulse.
- FSM has two states, BLANK and RUN. The state machine, mode register and counters all reset to: BLANK, mode 0, counters 0, debounced levels 0.
- BLANK:
  - OUT_ENABLE = 0.
  - Pin outputs show the mode number: OUT_SEG0SELE=4'b0001, OUT_SEG0DATA = digit pattern of OUT_MODE, with patterns 0..7 = 3F,06,5B,4F,66,6D,7D,07 hex.
  - OUT_SEG1SELE=0, OUT_SEG1DATA=0, both DPs 0, OUT_LED=0.
  - The blank counter counts BLANK_CYC cycles, then the FSM goes to RUN.
- RUN:
  - OUT_ENABLE = one-hot of mode.
  - All pin outputs = registered copy of the selected mode's input slice.
  - On a NEXT pulse alone: mode = mode+1, wrapping N_MODES-1→0. Go to BLANK with the blank counter cleared.
  - On a PREV pulse alone: mode = mode-1, wrapping 0→N_MODES-1. Go to BLANK with the blank counter cleared.
  - NEXT and PREV pulses in the same cycle are ignored; mode and state are unchanged.
- Press pulses arriving in BLANK are discarded; they do not queue or extend the blank.
- Debounce keeps running in BLANK. A button held through BLANK produces no second pulse until it is released (debounced to 0) and pressed again.
- IN_RST asserted at any time returns to the reset state at the next edge, including mid-BLANK or mid-debounce.

## Timing
- All outputs are registered.
- Reset values: OUT_ENABLE=0, OUT_MODE=0, all seg/dp/LED outputs 0.
- The first BLANK display (digit 0 pattern 3F) appears on the edge after IN_RST is sampled low.
- Press latency: raw input sampled high at edge t → press pulse during cycle t+2+DEBOUNCE_CYC.
  - OUT_MODE updates and OUT_ENABLE goes to 0 on the next edge.
- BLANK duration: OUT_ENABLE stays 0 for exactly BLANK_CYC cycles, then asserts its new one-hot value.
- RUN data path: a mode input change reaches the pins one cycle later.
- Switch boundaries:
  - The last RUN output cycle shows the old mode's data.
  - The first BLANK cycle shows the new mode digit.
  - The first RUN cycle after BLANK shows the new mode's data registered during the final BLANK cycle.
- Power-up: first RUN with ENABLE[0]=1 occurs BLANK_CYC cycles after reset release.

## Test plan
Bench parameters: N_MODES=4, DEBOUNCE_CYC=4, BLANK_CYC=8.
1. Reset, then release → OUT_ENABLE=0 and OUT_SEG0DATA=3F for 8 cycles; then OUT_ENABLE=0001, OUT_MODE=0, and OUT_LED follows IN_M_LED[15:0] with 1-cycle lag.
2. NEXT high for 10 cycles, repeated 4 times with releases → OUT_MODE sequence 1,2,3,0 (wrap).
   - Each switch gives 8 blank cycles with segment patterns 06, 5B, 4F, 3F.
3. NEXT glitch high for 3 cycles, then low → no mode change, OUT_ENABLE unchanged.
4. From mode 0, PREV press → OUT_MODE=3, OUT_ENABLE=1000 after the blank.
   - A PREV press issued during the blank is ignored; OUT_MODE stays 3.
5. NEXT and PREV raised on the same cycle and held 10 cycles → pulses coincide, mode unchanged, no blank entered.
6. IN_RST asserted in the 4th blank cycle after switching to mode 2 → next edge gives OUT_MODE=0 and all outputs 0; then a fresh 8-cycle blank before ENABLE=0001.
